sl_transmitter: RTL and testbench

Transmit side of the two-wire SL serial link, driving the same active-low zeroes/ones line pair that the SL receiver samples. It accepts a parallel word of 8–32 bits with a start strobe, then serialises it LSB-first as timed low pulses: a pulse on the ones line for a 1, on the zeroes line for a 0. An optional parity symbol follows, and a stop symbol pulses both lines together. It sits in the 16 MHz `clk` domain beside the receiver; the APB-side configuration logic drives it.

---
 rtl/sl_pkg.sv | 37 +++
 rtl/sl_phase_timer.sv | 25 ++
 rtl/sl_transmitter.sv | 124 ++++++++++++
 tb/tb_sl_transmitter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// Shared definitions for the SL serial link: line-pair symbol encodings,
// FSM states, length/phase limits and small helpers used by both link ends.
package sl_pkg;

    localparam int SL_MIN_LEN   = 8;
    localparam int SL_MAX_LEN   = 32;
    localparam int SL_MIN_PHASE = 12;

    // Symbols are the line pair {sl1_n, sl0_n}; both lines are active-low.
    localparam logic [1:0] SYM_ZERO = 2'b10;
    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_STOP = 2'b00;
    localparam logic [1:0] SYM_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } sl_state_e;

    function automatic logic [5:0] sl_clamp_len(input logic [5:0] len);
        if (len < 6'(SL_MIN_LEN))
            return 6'(SL_MIN_LEN);
        else if (len > 6'(SL_MAX_LEN))
            return 6'(SL_MAX_LEN);
        else
            return len;
    endfunction

    // Odd parity over data plus parity: 1 when the word holds an even number of ones.
    function automatic logic sl_parity(input logic [31:0] data, input logic [5:0] len);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF >> (6'd32 - len);
        return ~(^(data & mask));
    endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// Loadable down-counter timing one PULSE or GAP phase; o_tc flags the last cycle.
module sl_phase_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != '0)
            r_count <= r_count - WIDTH'(1);
    end

    assign o_tc = (r_count == WIDTH'(1));

endmodule

// File: rtl/sl_transmitter.sv
// SL link transmitter: serialises a latched word LSB-first as timed low pulses
// on the zeroes/ones line pair, with optional odd parity and a stop symbol.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int PULSE_CYCLES = 16,
    parameter int GAP_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_word_len,
    input  logic        i_parity_en,
    output logic        o_sl0_n,
    output logic        o_sl1_n,
    output logic        o_busy,
    output logic        o_done
);

    if (PULSE_CYCLES < SL_MIN_PHASE || GAP_CYCLES < SL_MIN_PHASE) begin : g_bad_phase
        $error("sl_transmitter: PULSE_CYCLES and GAP_CYCLES must be at least SL_MIN_PHASE");
    end

    sl_state_e   r_state;
    logic [31:0] r_data;
    logic [5:0]  r_len;
    logic        r_par_en;
    logic        r_par_bit;
    logic [5:0]  r_idx;
    logic [1:0]  r_lines;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_tc;
    logic        w_last;
    logic        w_word_end;
    logic        w_load;
    logic [15:0] w_load_val;
    logic [1:0]  w_sym;
    logic [5:0]  w_len_clamped;

    assign w_len_clamped = sl_clamp_len(i_word_len);
    assign w_accept      = (r_state == ST_IDLE) && i_start;
    assign w_last        = (r_idx == r_len + {5'd0, r_par_en});
    assign w_word_end    = (r_state == ST_GAP) && w_tc && w_last;

    // The timer is reloaded at every phase boundary except the end of the word.
    assign w_load = w_accept
                 || ((r_state == ST_PULSE) && w_tc)
                 || ((r_state == ST_GAP) && w_tc && !w_last);
    assign w_load_val = (r_state == ST_PULSE) ? 16'(GAP_CYCLES) : 16'(PULSE_CYCLES);

    sl_phase_timer #(
        .WIDTH (16)
    ) u_phase_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_sym = SYM_STOP;
        if (r_idx < r_len)
            w_sym = r_data[r_idx[4:0]] ? SYM_ONE : SYM_ZERO;
        else if (r_par_en && (r_idx == r_len))
            w_sym = r_par_bit ? SYM_ONE : SYM_ZERO;
    end

    // Outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_len     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_idx     <= '0;
            r_lines   <= SYM_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_data    <= i_data;
                        r_len     <= w_len_clamped;
                        r_par_en  <= i_parity_en;
                        r_par_bit <= sl_parity(i_data, w_len_clamped);
                        r_idx     <= '0;
                        r_state   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_tc)
                        r_state <= ST_GAP;
                end
                ST_GAP: begin
                    if (w_tc) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= ST_PULSE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            r_lines <= (r_state == ST_PULSE) ? w_sym : SYM_IDLE;
            r_busy  <= (r_state != ST_IDLE) && !w_word_end;
            r_done  <= w_word_end;
        end
    end

    assign o_sl1_n = r_lines[1];
    assign o_sl0_n = r_lines[0];
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_sl_transmitter.sv
// Self-checking bench for sl_transmitter: a negedge loopback monitor decodes the
// line pair and checks every symbol against a scoreboard filled when words start.
module tb_sl_transmitter;

    localparam int PULSE = 16;
    localparam int GAP   = 16;
    localparam int SYM   = PULSE + GAP;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data;
    logic [5:0]  wordLen;
    logic        parityEn;
    logic        sl0N;
    logic        sl1N;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int expQ[$];
    int zeroLowCnt = 0;

    bit inPulse = 0;
    bit inWord  = 0;
    int highCnt = GAP;
    int pulseLen = 0;
    logic [1:0] curLines = 2'b11;

    sl_transmitter #(
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_data      (data),
        .i_word_len  (wordLen),
        .i_parity_en (parityEn),
        .o_sl0_n     (sl0N),
        .o_sl1_n     (sl1N),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback receiver: symbols are 0, 1 or 2 (stop), decoded from {sl1_n, sl0_n}.
    always @(negedge clk) begin
        logic [1:0] lines;
        int sym;
        int exp;
        if (!rst_n) begin
            inPulse = 0;
            inWord  = 0;
            highCnt = GAP;
        end else begin
            lines = {sl1N, sl0N};
            if (!sl0N) zeroLowCnt++;
            if (lines == 2'b11) begin
                if (inPulse) begin
                    checks++;
                    if (pulseLen !== PULSE) begin
                        errors++;
                        $display("[TB] FAIL pulse_len: got %0d cycles, want %0d", pulseLen, PULSE);
                    end
                    inPulse = 0;
                    highCnt = 0;
                end
                highCnt++;
            end else if (!inPulse) begin
                inPulse  = 1;
                pulseLen = 1;
                curLines = lines;
                sym = (lines == 2'b01) ? 1 : (lines == 2'b10) ? 0 : 2;
                checks++;
                if (inWord ? (highCnt != GAP) : (highCnt < GAP)) begin
                    errors++;
                    $display("[TB] FAIL gap_len: got %0d high cycles, want %s%0d", highCnt, inWord ? "" : ">=", GAP);
                end
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_symbol: got %0d, want none", sym);
                end else begin
                    exp = expQ.pop_front();
                    if (sym != exp) begin
                        errors++;
                        $display("[TB] FAIL symbol: got %0d, want %0d", sym, exp);
                    end
                end
                inWord = (sym != 2);
            end else begin
                checks++;
                if (lines !== curLines) begin
                    errors++;
                    $display("[TB] FAIL pulse_level: got %b, want %b", lines, curLines);
                end
                pulseLen++;
            end
        end
    end

    // Drives a one-cycle start and queues the symbols the word should produce;
    // returns #1 after the accepting edge.
    task automatic startWord(input logic [31:0] d, input logic [5:0] len, input bit par);
        int n;
        int ones;
        n = (len < 8) ? 8 : (len > 32) ? 32 : int'(len);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            expQ.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        if (par) expQ.push_back((ones % 2 == 0) ? 1 : 0);
        expQ.push_back(2);
        @(posedge clk);
        #1;
        data     = d;
        wordLen  = len;
        parityEn = par;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles since acceptance until done; -1 if the budget runs out.
    task automatic waitDone(input int offset, output int cyc);
        cyc = offset;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (cyc > 3000) begin
                cyc = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sl0N !== 1'b1) begin errors++; $display("[TB] FAIL reset_sl0: got %b, want 1", sl0N); end
        checks++; if (sl1N !== 1'b1) begin errors++; $display("[TB] FAIL reset_sl1: got %b, want 1", sl1N); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, want 0", done); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_a5_parity();
        int cyc;
        startWord(32'h0000_00A5, 6'd8, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL a5_busy_latency: got %b, want 0", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL a5_busy_rise: got %b, want 1", busy); end
        checks++; if ({sl1N, sl0N} !== 2'b01) begin errors++; $display("[TB] FAIL a5_first_pulse: got %b, want 01", {sl1N, sl0N}); end
        waitDone(1, cyc);
        checks++; if (cyc != 10 * SYM) begin errors++; $display("[TB] FAIL a5_duration: got %0d, want %0d", cyc, 10 * SYM); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL a5_busy_at_done: got %b, want 0", busy); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL a5_done_width: got %b, want 0", done); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL a5_leftover: got %0d symbols, want 0", expQ.size()); end
    endtask

    task automatic test_all_ones();
        int cyc;
        zeroLowCnt = 0;
        startWord(32'hFFFF_FFFF, 6'd32, 1'b0);
        waitDone(0, cyc);
        checks++; if (cyc != 33 * SYM) begin errors++; $display("[TB] FAIL ones_duration: got %0d, want %0d", cyc, 33 * SYM); end
        checks++; if (zeroLowCnt != PULSE) begin errors++; $display("[TB] FAIL ones_sl0_low: got %0d cycles, want %0d", zeroLowCnt, PULSE); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL ones_leftover: got %0d symbols, want 0", expQ.size()); end
    endtask

    task automatic test_clamp();
        int cyc;
        startWord(32'h1234_5678, 6'd5, 1'b1);
        waitDone(0, cyc);
        checks++; if (cyc != 10 * SYM) begin errors++; $display("[TB] FAIL clamp_low: got %0d, want %0d", cyc, 10 * SYM); end
        startWord(32'h8765_4321, 6'd40, 1'b0);
        waitDone(0, cyc);
        checks++; if (cyc != 33 * SYM) begin errors++; $display("[TB] FAIL clamp_high: got %0d, want %0d", cyc, 33 * SYM); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL clamp_leftover: got %0d symbols, want 0", expQ.size()); end
    endtask

    task automatic test_ignore_start();
        int cyc;
        int busyCnt;
        startWord(32'h0000_00A5, 6'd8, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        data    = 32'h0000_003C;
        wordLen = 6'd16;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(51, cyc);
        checks++; if (cyc != 9 * SYM) begin errors++; $display("[TB] FAIL ignore_duration: got %0d, want %0d", cyc, 9 * SYM); end
        busyCnt = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (busy) busyCnt++;
        end
        checks++; if (busyCnt != 0) begin errors++; $display("[TB] FAIL ignore_second_word: got %0d busy cycles, want 0", busyCnt); end
    endtask

    task automatic test_reset_midword();
        int cyc;
        bit sawDone;
        startWord(32'h0000_000F, 6'd8, 1'b1);
        repeat (100) @(posedge clk);
        #3;
        checks++; if ({sl1N, sl0N} !== 2'b01) begin errors++; $display("[TB] FAIL midword_4th_pulse: got %b, want 01", {sl1N, sl0N}); end
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checks++; if ({sl1N, sl0N} !== 2'b11) begin errors++; $display("[TB] FAIL midword_lines: got %b, want 11", {sl1N, sl0N}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midword_busy: got %b, want 0", busy); end
        sawDone = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
        end
        checks++; if (sawDone) begin errors++; $display("[TB] FAIL midword_done: got 1, want 0"); end
        startWord(32'h0000_000F, 6'd8, 1'b1);
        waitDone(0, cyc);
        checks++; if (cyc != 10 * SYM) begin errors++; $display("[TB] FAIL midword_restart: got %0d, want %0d", cyc, 10 * SYM); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL midword_leftover: got %0d symbols, want 0", expQ.size()); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        startWord(32'h0000_005A, 6'd8, 1'b1);
        waitDone(0, cyc);
        checks++; if (cyc != 10 * SYM) begin errors++; $display("[TB] FAIL b2b_word1: got %0d, want %0d", cyc, 10 * SYM); end
        startWord(32'h0000_C3C3, 6'd16, 1'b0);
        waitDone(0, cyc);
        checks++; if (cyc != 17 * SYM) begin errors++; $display("[TB] FAIL b2b_word2: got %0d, want %0d", cyc, 17 * SYM); end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_leftover: got %0d symbols, want 0", expQ.size()); end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        data     = '0;
        wordLen  = 6'd8;
        parityEn = 1'b0;
        test_reset();
        test_a5_parity();
        test_all_ones();
        test_clamp();
        test_ignore_start();
        test_reset_midword();
        test_back_to_back();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
